// File: rtl/histogram_top.sv
// Binary 3x3 median filter streaming between two external pixel memories,
// with per-column and per-row counters of the filtered 1-pixels.
module histogram_top #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 180,
    parameter int ADDR_W = 8,
    parameter int THRESH = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              filterReady,
    output logic              filterDone,
    input  logic              dataIn,
    output logic [ADDR_W-1:0] xAddressOut,
    output logic [ADDR_W-1:0] yAddressOut,
    output logic [ADDR_W-1:0] xMedianAddress,
    output logic [ADDR_W-1:0] yMedianAddress,
    output logic              writeEnable,
    output logic              dataOut,
    input  logic              readHistogram,
    input  logic              clearHistogram,
    output logic [7:0]        xHistogramOut,
    output logic [7:0]        yHistogramOut,
    output logic              xValid,
    output logic              yValid,
    output logic              histogramCleared
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fstate_t;
    typedef enum logic [1:0] {HIDLE, STREAM, HDONE} hstate_t;

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(HEIGHT - 1);
    localparam logic [3:0]        THRESH_L = 4'(THRESH);

    fstate_t           fstate_q, fstate_d;
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              inb_q, inb_d;

    hstate_t           hstate_q, hstate_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_ack_q, clr_ack_d;
    logic              clr_hold_q, clr_hold_d;
    logic              clr_fire;

    logic [7:0] xbin_q [WIDTH];
    logic [7:0] xbin_d [WIDTH];
    logic [7:0] ybin_q [HEIGHT];
    logic [7:0] ybin_d [HEIGHT];

    logic [1:0]        dx, dy;
    logic              x_lo, x_hi, y_lo, y_hi, nb_in;
    logic [ADDR_W-1:0] nb_x, nb_y;
    logic [3:0]        pix_cnt;
    logic              run, we, pix_out;

    // Neighbour k of the window: dx-major, so dx = k/3 and dy = k%3 (offset by -1).
    always_comb begin
        dx = 2'd2;
        dy = 2'd2;
        case (k_q)
            4'd0, 4'd1, 4'd2: dx = 2'd0;
            4'd3, 4'd4, 4'd5: dx = 2'd1;
            default:          dx = 2'd2;
        endcase
        case (k_q)
            4'd0, 4'd3, 4'd6: dy = 2'd0;
            4'd1, 4'd4, 4'd7: dy = 2'd1;
            default:          dy = 2'd2;
        endcase
        x_lo  = (dx == 2'd0) && (x_q == '0);
        x_hi  = (dx == 2'd2) && (x_q == X_LAST);
        y_lo  = (dy == 2'd0) && (y_q == '0);
        y_hi  = (dy == 2'd2) && (y_q == Y_LAST);
        nb_in = !(x_lo || x_hi || y_lo || y_hi);
        nb_x  = x_lo ? '0 : (x_hi ? X_LAST : x_q + ADDR_W'(dx) - ADDR_W'(1));
        nb_y  = y_lo ? '0 : (y_hi ? Y_LAST : y_q + ADDR_W'(dy) - ADDR_W'(1));
    end

    assign run     = (fstate_q == RUN);
    assign we      = run && (k_q == 4'd9);
    assign pix_cnt = cnt_q + {3'b000, dataIn & inb_q};
    assign pix_out = (pix_cnt >= THRESH_L);

    always_comb begin
        fstate_d = fstate_q;
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        inb_d    = 1'b0;
        case (fstate_q)
            IDLE: begin
                if (start) begin
                    fstate_d = RUN;
                    x_d      = '0;
                    y_d      = '0;
                    k_d      = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                inb_d = nb_in;
                if (k_q == 4'd9) begin
                    k_d   = '0;
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d = '0;
                        if (x_q == X_LAST) fstate_d = DONE;
                        else               x_d = x_q + ADDR_W'(1);
                    end else begin
                        y_d = y_q + ADDR_W'(1);
                    end
                end else begin
                    k_d   = k_q + 4'd1;
                    // Data arriving during c0 belongs to the previous window's last read.
                    cnt_d = (k_q == 4'd0) ? 4'd0 : pix_cnt;
                end
            end
            DONE: begin
                if (!start) fstate_d = IDLE;
            end
            default: fstate_d = IDLE;
        endcase
    end

    // A held clear acknowledges once; the hold flag also lets a simultaneous read follow.
    always_comb begin
        hstate_d   = hstate_q;
        idx_d      = idx_q;
        clr_fire   = 1'b0;
        case (hstate_q)
            HIDLE: begin
                if (!run) begin
                    if (clearHistogram && !clr_hold_q) begin
                        clr_fire = 1'b1;
                    end else if (readHistogram) begin
                        hstate_d = STREAM;
                        idx_d    = '0;
                    end
                end
            end
            STREAM: begin
                if (idx_q == X_LAST) hstate_d = HDONE;
                else                 idx_d = idx_q + ADDR_W'(1);
            end
            HDONE: begin
                if (!readHistogram) hstate_d = HIDLE;
            end
            default: hstate_d = HIDLE;
        endcase
        clr_ack_d  = clr_fire;
        clr_hold_d = clearHistogram && (clr_hold_q || clr_fire);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            xbin_d[i] = xbin_q[i];
            if (clr_fire)
                xbin_d[i] = 8'd0;
            else if (we && pix_out && (x_q == ADDR_W'(i)))
                xbin_d[i] = xbin_q[i] + 8'd1;
        end
        for (int i = 0; i < HEIGHT; i++) begin
            ybin_d[i] = ybin_q[i];
            if (clr_fire)
                ybin_d[i] = 8'd0;
            else if (we && pix_out && (y_q == ADDR_W'(i)))
                ybin_d[i] = ybin_q[i] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fstate_q   <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            inb_q      <= 1'b0;
            hstate_q   <= HIDLE;
            idx_q      <= '0;
            clr_ack_q  <= 1'b0;
            clr_hold_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++)  xbin_q[i] <= 8'd0;
            for (int i = 0; i < HEIGHT; i++) ybin_q[i] <= 8'd0;
        end else begin
            fstate_q   <= fstate_d;
            x_q        <= x_d;
            y_q        <= y_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            inb_q      <= inb_d;
            hstate_q   <= hstate_d;
            idx_q      <= idx_d;
            clr_ack_q  <= clr_ack_d;
            clr_hold_q <= clr_hold_d;
            for (int i = 0; i < WIDTH; i++)  xbin_q[i] <= xbin_d[i];
            for (int i = 0; i < HEIGHT; i++) ybin_q[i] <= ybin_d[i];
        end
    end

    assign filterReady      = (fstate_q == IDLE);
    assign filterDone       = (fstate_q == DONE);
    assign xAddressOut      = run ? nb_x : '0;
    assign yAddressOut      = run ? nb_y : '0;
    assign writeEnable      = we;
    assign dataOut          = we && pix_out;
    assign xMedianAddress   = we ? x_q : '0;
    assign yMedianAddress   = we ? y_q : '0;
    assign xValid           = (hstate_q == STREAM);
    assign yValid           = xValid && ({1'b0, idx_q} < (ADDR_W + 1)'(HEIGHT));
    assign xHistogramOut    = xValid ? xbin_q[idx_q] : 8'd0;
    assign yHistogramOut    = yValid ? ybin_q[idx_q] : 8'd0;
    assign histogramCleared = clr_ack_q;

endmodule

// File: tb/tb_histogram_top.sv
// Scoreboard bench for histogram_top on a reduced 8x6 image: stimulus queues
// expected writes and bins, a negedge monitor pops and compares them.
module tb_histogram_top;
    localparam int W       = 8;
    localparam int H       = 6;
    localparam int AW      = 3;
    localparam int TH      = 5;
    localparam int RUN_CYC = W * H * 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          data_in = 1'b0;
    logic          read_h = 1'b0;
    logic          clear_h = 1'b0;
    logic          filter_ready, filter_done, write_en, data_out;
    logic [AW-1:0] x_addr, y_addr, x_med, y_med;
    logic [7:0]    x_hist, y_hist;
    logic          x_valid, y_valid, hist_cleared;

    always #5 clk = ~clk;

    histogram_top #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .THRESH(TH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .filterReady(filter_ready), .filterDone(filter_done),
        .dataIn(data_in), .xAddressOut(x_addr), .yAddressOut(y_addr),
        .xMedianAddress(x_med), .yMedianAddress(y_med),
        .writeEnable(write_en), .dataOut(data_out),
        .readHistogram(read_h), .clearHistogram(clear_h),
        .xHistogramOut(x_hist), .yHistogramOut(y_hist),
        .xValid(x_valid), .yValid(y_valid), .histogramCleared(hist_cleared)
    );

    logic src [W][H];
    always @(posedge clk) data_in <= src[x_addr][y_addr];

    typedef struct { int x; int y; int d; } pix_t;
    pix_t exp_pix[$];
    int   exp_x[$];
    int   exp_y[$];
    int   model_x [W];
    int   model_y [H];
    int   checks = 0;
    int   errors = 0;
    int   xv_cnt = 0;
    int   yv_cnt = 0;
    int   clr_cnt = 0;

    int hand_x [W] = '{4, 6, 6, 6, 6, 6, 6, 4};
    int hand_y [H] = '{6, 8, 8, 8, 8, 6};

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (write_en) begin
            if (exp_pix.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                pix_t p;
                p = exp_pix.pop_front();
                chk("pix_x", int'(x_med), p.x);
                chk("pix_y", int'(y_med), p.y);
                chk("pix_d", int'(data_out), p.d);
                $display("write (%0d,%0d) d=%0d", x_med, y_med, data_out);
            end
        end
        if (x_valid) begin
            xv_cnt++;
            if (exp_x.size() == 0) chk("unexpected_xbin", 1, 0);
            else begin
                int e;
                e = exp_x.pop_front();
                chk("xbin", int'(x_hist), e);
                $display("xbin %0d", x_hist);
            end
        end
        if (y_valid) begin
            yv_cnt++;
            if (exp_y.size() == 0) chk("unexpected_ybin", 1, 0);
            else begin
                int e;
                e = exp_y.pop_front();
                chk("ybin", int'(y_hist), e);
                $display("ybin %0d", y_hist);
            end
        end
        if (hist_cleared) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int med(input int x, input int y);
        int c = 0;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    c += int'(src[x + dx][y + dy]);
        return (c >= TH) ? 1 : 0;
    endfunction

    task automatic fill(input int mode);
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                src[x][y] = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'(mode);
    endtask

    task automatic zero_model();
        for (int i = 0; i < W; i++) model_x[i] = 0;
        for (int i = 0; i < H; i++) model_y[i] = 0;
    endtask

    task automatic push_expected();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) begin
                pix_t p;
                p.x = x; p.y = y; p.d = med(x, y);
                exp_pix.push_back(p);
                model_x[x] += p.d;
                model_y[y] += p.d;
            end
    endtask

    task automatic run_filter();
        int n;
        push_expected();
        start = 1'b1;
        tick();
        chk("ready_fall", int'(filter_ready), 0);
        chk("first_addr", int'({x_addr, y_addr}), 0);
        n = 1;
        while (!filter_done && n < RUN_CYC + 10) begin
            tick();
            n++;
        end
        chk("run_len_ok", int'(n >= RUN_CYC + 1 && n <= RUN_CYC + 3), 1);
        chk("done_high", int'(filter_done), 1);
        start = 1'b0;
        tick();
        tick();
        chk("ready_back", int'(filter_ready), 1);
        chk("writes_left", exp_pix.size(), 0);
    endtask

    task automatic read_hist(input bit hand);
        int bx, by, n;
        for (int i = 0; i < W; i++) exp_x.push_back(hand ? hand_x[i] : model_x[i]);
        for (int i = 0; i < H; i++) exp_y.push_back(hand ? hand_y[i] : model_y[i]);
        bx = xv_cnt;
        by = yv_cnt;
        read_h = 1'b1;
        tick();
        chk("stream_latency", int'(x_valid), 1);
        n = 0;
        while ((xv_cnt - bx) < W && n < W + 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        read_h = 1'b0;
        tick();
        tick();
        chk("xvalid_count", xv_cnt - bx, W);
        chk("yvalid_count", yv_cnt - by, H);
        chk("bins_left", exp_x.size() + exp_y.size(), 0);
    endtask

    task automatic clear_hist();
        int c0;
        zero_model();
        c0 = clr_cnt;
        clear_h = 1'b1;
        repeat (4) tick();
        clear_h = 1'b0;
        tick();
        chk("clear_pulses", clr_cnt - c0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, bx, n;
        fill(0);
        zero_model();
        tick();
        tick();
        chk("rst_ready", int'(filter_ready), 1);
        chk("rst_done", int'(filter_done), 0);
        chk("rst_we", int'(write_en), 0);
        chk("rst_valid", int'({x_valid, y_valid, hist_cleared}), 0);
        chk("rst_addr", int'({x_addr, y_addr}), 0);
        reset = 1'b1;
        tick();

        // all-zero source
        run_filter();
        read_hist(1'b0);

        // all-one source: corners drop out
        fill(1);
        run_filter();
        read_hist(1'b1);

        // clear and read in the same cycle: clear first, then a zero stream
        zero_model();
        for (int i = 0; i < W; i++) exp_x.push_back(0);
        for (int i = 0; i < H; i++) exp_y.push_back(0);
        c0 = clr_cnt;
        bx = xv_cnt;
        clear_h = 1'b1;
        read_h = 1'b1;
        n = 0;
        while ((xv_cnt - bx) < W && n < W + 20) begin
            tick();
            n++;
        end
        tick();
        clear_h = 1'b0;
        read_h = 1'b0;
        tick();
        tick();
        chk("clr_read_pulses", clr_cnt - c0, 1);
        chk("clr_read_stream", xv_cnt - bx, W);
        chk("clr_read_left", exp_x.size() + exp_y.size(), 0);

        // requests during RUN are ignored; bins survive
        fork
            run_filter();
            begin
                int cc;
                repeat (100) @(posedge clk);
                #1;
                cc = clr_cnt;
                clear_h = 1'b1;
                read_h = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                clear_h = 1'b0;
                read_h = 1'b0;
                chk("run_clear_ignored", clr_cnt - cc, 0);
            end
        join
        read_hist(1'b1);

        // isolated pixels vanish
        clear_hist();
        fill(0);
        src[4][3] = 1'b1;
        src[0][0] = 1'b1;
        run_filter();
        read_hist(1'b0);

        // random source against the software majority
        fill(2);
        run_filter();
        read_hist(1'b0);

        // reset mid-run aborts, clears bins, and a fresh run is complete
        fill(1);
        push_expected();
        start = 1'b1;
        repeat (101) tick();
        reset = 1'b0;
        tick();
        exp_pix.delete();
        zero_model();
        chk("abort_ready", int'(filter_ready), 1);
        chk("abort_we", int'(write_en), 0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        read_hist(1'b0);
        run_filter();
        read_hist(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
